// File: rtl/yolo_pkg.sv
// rtl/yolo_pkg.sv - shared constants, FSM encoding and header packing for the packetizer
package yolo_pkg;

  localparam logic [2:0] LAYER_CONV2D  = 3'd1;
  localparam logic [2:0] LAYER_CH_ADD  = 3'd2;
  localparam logic [2:0] LAYER_MAXPOOL = 3'd3;
  localparam logic [2:0] LAYER_RELU    = 3'd4;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } pkt_state_e;

  function automatic logic [31:0] make_hdr(input logic [2:0] layer, input logic [15:0] len);
    return {HDR_MAGIC, 5'b0, layer, len};
  endfunction

endpackage

// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - DEPTH-entry word FIFO carrying a last flag, head visible combinationally
module axis_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic [31:0] push_data_i,
  input  logic        push_last_i,
  input  logic        pop_i,
  output logic [31:0] head_data_o,
  output logic        head_last_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [32:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign {head_last_o, head_data_o} = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
  end

endmodule

// File: rtl/axis_packetizer.sv
// rtl/axis_packetizer.sv - splits a word stream into fixed-length packets for the DRAM DMA
// Optional header beat per packet when YOLO_PKT_HDR_EN is defined.
module axis_packetizer
  import yolo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = 16
) (
  input  logic             M_AXIS_ACLK,
  input  logic             M_AXIS_ARESETN,
  input  logic [LEN_W-1:0] cfg_pkt_len,
  input  logic [2:0]       cfg_layer,
  input  logic [31:0]      S_AXIS_TDATA,
  input  logic             S_AXIS_TVALID,
  input  logic             S_AXIS_TLAST,
  output logic             S_AXIS_TREADY,
  output logic [31:0]      M_AXIS_TDATA,
  output logic [3:0]       M_AXIS_TKEEP,
  output logic             M_AXIS_TVALID,
  output logic             M_AXIS_TLAST,
  input  logic             M_AXIS_TREADY,
  output logic [LEN_W-1:0] pkt_count,
  output logic             busy
);
  pkt_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [2:0]       layer_q, layer_d;
  logic             ready_en_q;

  logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [31:0]      head_data;
  logic             head_last;
  logic             out_valid, out_last;
  logic [31:0]      out_data;

  // Ready stays low until the first clock edge after reset release.
  assign S_AXIS_TREADY = ready_en_q && !fifo_full;
  assign fifo_push     = S_AXIS_TVALID && S_AXIS_TREADY;

  axis_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (M_AXIS_ACLK),
    .rst_ni      (M_AXIS_ARESETN),
    .push_i      (fifo_push),
    .push_data_i (S_AXIS_TDATA),
    .push_last_i (S_AXIS_TLAST),
    .pop_i       (fifo_pop),
    .head_data_o (head_data),
    .head_last_o (head_last),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

`ifndef YOLO_PKT_HDR_EN
  logic unused_layer;
  assign unused_layer = ^layer_q;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    layer_d   = layer_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          len_d   = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
          layer_d = cfg_layer;
          beat_d  = '0;
`ifdef YOLO_PKT_HDR_EN
          state_d = ST_HDR;
`else
          state_d = ST_DATA;
`endif
        end
      end
`ifdef YOLO_PKT_HDR_EN
      ST_HDR: begin
        out_valid = 1'b1;
        out_data  = make_hdr(layer_q, 16'(len_q));
        if (M_AXIS_TREADY) state_d = ST_DATA;
      end
`endif
      ST_DATA: begin
        out_valid = !fifo_empty;
        if (!fifo_empty) begin
          out_data = head_data;
          out_last = (beat_q == len_q - LEN_W'(1)) || head_last;
          if (M_AXIS_TREADY) begin
            fifo_pop = 1'b1;
            if (out_last) begin
              state_d = ST_IDLE;
              beat_d  = '0;
              cnt_d   = cnt_q + LEN_W'(1);
            end else begin
              beat_d  = beat_q + LEN_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      layer_q    <= '0;
      beat_q     <= '0;
      cnt_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      layer_q    <= layer_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      ready_en_q <= 1'b1;
    end
  end

  assign M_AXIS_TVALID = out_valid;
  assign M_AXIS_TDATA  = out_data;
  assign M_AXIS_TLAST  = out_last;
  assign M_AXIS_TKEEP  = out_valid ? 4'hF : 4'h0;
  assign pkt_count     = cnt_q;
  assign busy          = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_packetizer.sv
// tb/tb_axis_packetizer.sv - directed and randomized checks of axis_packetizer against a packet model
module tb_axis_packetizer;
  localparam int DEPTH = 16;
  localparam int LEN_W = 8;
  typedef logic [32:0] beat_q_t [$];

  logic             clk = 1'b0;
  logic             rst_n;
  logic [LEN_W-1:0] cfg_pkt_len;
  logic [2:0]       cfg_layer;
  logic [31:0]      s_tdata;
  logic             s_tvalid, s_tlast, s_tready;
  logic [31:0]      m_tdata;
  logic [3:0]       m_tkeep;
  logic             m_tvalid, m_tlast, m_tready;
  logic [LEN_W-1:0] pkt_count;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int exp_pkts = 0;
  beat_q_t src, acc, got;

  always #5 clk = ~clk;

  axis_packetizer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .cfg_pkt_len    (cfg_pkt_len),
    .cfg_layer      (cfg_layer),
    .S_AXIS_TDATA   (s_tdata),
    .S_AXIS_TVALID  (s_tvalid),
    .S_AXIS_TLAST   (s_tlast),
    .S_AXIS_TREADY  (s_tready),
    .M_AXIS_TDATA   (m_tdata),
    .M_AXIS_TKEEP   (m_tkeep),
    .M_AXIS_TVALID  (m_tvalid),
    .M_AXIS_TLAST   (m_tlast),
    .M_AXIS_TREADY  (m_tready),
    .pkt_count      (pkt_count),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packets close after L words or at an upstream last; length 0 means 1.
  function automatic beat_q_t model(input beat_q_t in_q, input int len, input logic [2:0] layer);
    beat_q_t o;
    int L = (len == 0) ? 1 : len;
    int k = 0;
    foreach (in_q[i]) begin
`ifdef YOLO_PKT_HDR_EN
      if (k == 0) o.push_back({1'b0, 8'hA5, 5'b0, layer, 16'(L)});
`else
      if (layer == 3'd7 && k < 0) o.push_back('0);
`endif
      if (k == L - 1 || in_q[i][32]) begin
        o.push_back({1'b1, in_q[i][31:0]});
        k = 0;
      end else begin
        o.push_back({1'b0, in_q[i][31:0]});
        k++;
      end
    end
    return o;
  endfunction

  function automatic int count_lasts(input beat_q_t q);
    int n = 0;
    foreach (q[i]) if (q[i][32]) n++;
    return n;
  endfunction

  function automatic logic [32:0] rand_word(input bit last);
    return {last, 32'($urandom)};
  endfunction

  task automatic setup(input int len, input logic [2:0] layer);
    src.delete();
    acc.delete();
    got.delete();
    cfg_pkt_len = LEN_W'(len);
    cfg_layer   = layer;
  endtask

  task automatic run(input int max_cycles, input int rdy_pct, input int vld_pct,
                     input int max_beats, input bit need_done);
    beat_q_t e;
    int cyc = 0;
    bit done = 0;
    bit stalled = 0;
    logic [32:0] held = '0;
    while (!done && cyc < max_cycles) begin
      @(negedge clk);
      s_tvalid = (src.size() > 0) && ($urandom_range(99) < vld_pct);
      if (s_tvalid) {s_tlast, s_tdata} = src[0];
      else {s_tlast, s_tdata} = '0;
      m_tready = ($urandom_range(99) < rdy_pct);
      #1;
      if (s_tvalid && s_tready) acc.push_back(src.pop_front());
      if (stalled) chk("hold_stable", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, held}));
      if (m_tvalid) begin
        chk("tkeep", 64'(m_tkeep), 64'(4'hF));
        if (m_tready) got.push_back({m_tlast, m_tdata});
      end else begin
        chk("idle_zero", 64'({m_tlast, m_tdata}), 64'(0));
      end
      stalled = m_tvalid && !m_tready;
      held = {m_tlast, m_tdata};
      cyc++;
      if (max_beats > 0 && got.size() >= max_beats) done = 1;
      else if (src.size() == 0) begin
        e = model(acc, int'(cfg_pkt_len), cfg_layer);
        if (got.size() >= e.size()) done = 1;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 0;
    s_tlast  = 0;
    s_tdata  = '0;
    m_tready = 0;
    if (need_done) chk("run_complete", 64'(done), 64'(1));
  endtask

  task automatic verify(input string tag);
    beat_q_t e = model(acc, int'(cfg_pkt_len), cfg_layer);
    chk({tag, "_beats"}, 64'(got.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < got.size(); i++) chk({tag, "_beat"}, 64'(got[i]), 64'(e[i]));
    exp_pkts += count_lasts(e);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkts % (1 << LEN_W)));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(m_tvalid), 64'(0));
    chk({tag, "_tlast"},  64'(m_tlast), 64'(0));
    chk({tag, "_tdata"},  64'(m_tdata), 64'(0));
    chk({tag, "_tkeep"},  64'(m_tkeep), 64'(0));
    chk({tag, "_sready"}, 64'(s_tready), 64'(0));
    chk({tag, "_busy"},   64'(busy), 64'(0));
    chk({tag, "_pkts"},   64'(pkt_count), 64'(0));
  endtask

  initial begin
    logic [32:0] d0;
    beat_q_t e;
    rst_n = 0;
    s_tvalid = 0; s_tlast = 0; s_tdata = '0; m_tready = 0;
    cfg_pkt_len = '0; cfg_layer = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("tready_before_edge", 64'(s_tready), 64'(0));
    @(posedge clk);
    #1;
    chk("tready_after_release", 64'(s_tready), 64'(1));

    // len=4, 8 words, sink always ready
    setup(4, 3'd1);
    for (int i = 0; i < 8; i++) src.push_back(rand_word(0));
    run(400, 100, 100, 0, 1);
    chk("len4_lasts", 64'(count_lasts(got)), 64'(2));
    verify("len4");

    // len=8 with upstream last on word 5, then a full packet
    setup(8, 3'd2);
    for (int i = 0; i < 13; i++) src.push_back(rand_word(i == 4));
    run(400, 100, 100, 0, 1);
    verify("early_last");

    // sink stalled 20 cycles under continuous input
    setup(4, 3'd4);
    for (int i = 0; i < 24; i++) src.push_back(rand_word(0));
    run(20, 0, 100, 0, 0);
    chk("stall_accepted", 64'(acc.size()), 64'(DEPTH));
    chk("stall_sready", 64'(s_tready), 64'(0));
    chk("stall_no_output", 64'(got.size()), 64'(0));
    chk("stall_busy", 64'(busy), 64'(1));
    run(800, 100, 100, 0, 1);
    verify("stall");

    // layer 3, len 2: header (when enabled) then two data beats
    setup(2, 3'd3);
    d0 = rand_word(0);
    src.push_back(d0);
    src.push_back(rand_word(0));
    run(200, 100, 100, 0, 1);
    if (got.size() > 0) begin
`ifdef YOLO_PKT_HDR_EN
      chk("hdr_first_beat", 64'(got[0]), 64'({1'b0, 32'hA5030002}));
`else
      chk("hdr_first_beat", 64'(got[0]), 64'(d0));
`endif
    end
    verify("hdr");

    // reset after three beats of a len=4 packet
    setup(4, 3'd1);
    for (int i = 0; i < 4; i++) src.push_back(rand_word(0));
    run(200, 100, 100, 3, 1);
    e = model(acc, 4, 3'd1);
    for (int i = 0; i < got.size() && i < e.size(); i++) chk("pre_reset_beat", 64'(got[i]), 64'(e[i]));
    #1;
    rst_n = 0;
    #1;
    chk_reset_outputs("mid_reset");
    exp_pkts = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    setup(4, 3'd1);
    for (int i = 0; i < 4; i++) src.push_back(rand_word(0));
    run(200, 100, 100, 0, 1);
    if (got.size() > 0) chk("post_reset_last", 64'(got[got.size()-1][32]), 64'(1));
    verify("post_reset");

    // len=0 behaves as 1: every data beat closes a packet
    setup(0, 3'd4);
    for (int i = 0; i < 6; i++) src.push_back(rand_word(0));
    run(300, 100, 100, 0, 1);
    chk("len0_lasts", 64'(count_lasts(got)), 64'(6));
    verify("len0");

    // drive pkt_count through its wrap point
    setup(0, 3'd1);
    for (int i = 0; i < 300; i++) src.push_back(rand_word(0));
    run(20 * 300 + 100, 100, 100, 0, 1);
    verify("wrap");

    // randomized lengths, lasts and backpressure
    for (int r = 0; r < 4; r++) begin
      setup($urandom_range(6, 1), 3'($urandom_range(4, 1)));
      for (int i = 0; i < 30; i++) src.push_back(rand_word((i == 29) || ($urandom_range(99) < 15)));
      run(3000, 70, 70, 0, 1);
      verify("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_packetizer.md
AXIS_PACKETIZER -- requirements
Module: axis_packetizer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO depth in words (power of two, >=4).
REQ-002 SHALL have parameter LEN_W, default 16, meaning width of packet-length configuration and counters.
REQ-003 SHALL have port M_AXIS_ACLK  in  1  single clock for all logic; one clock, no other clock domains.
REQ-004 SHALL have port M_AXIS_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port cfg_pkt_len  in  LEN_W  data words per output packet.
REQ-006 SHALL have port cfg_layer  in  3  layer id (1 conv2d, 2 channel add, 3 maxpool, 4 relu).
REQ-007 SHALL have port S_AXIS_TDATA  in  32  result word from the active layer engine.
REQ-008 SHALL have port S_AXIS_TVALID  in  1  upstream word valid.
REQ-009 SHALL have port S_AXIS_TLAST  in  1  upstream end-of-result (early packet close).
REQ-010 SHALL have port S_AXIS_TREADY  out  1  packetizer accepts a word.
REQ-011 SHALL have port M_AXIS_TDATA  out  32  word to DRAM DMA.
REQ-012 SHALL have port M_AXIS_TKEEP  out  4  byte enables, always 4'hF while TVALID.
REQ-013 SHALL have port M_AXIS_TVALID  out  1  output word valid.
REQ-014 SHALL have port M_AXIS_TLAST  out  1  last word of packet.
REQ-015 SHALL have port M_AXIS_TREADY  in  1  DMA accepts word.
REQ-016 SHALL have port pkt_count  out  LEN_W  packets completed, wraps modulo 2^LEN_W.
REQ-017 SHALL have port busy  out  1  high whenever FIFO non-empty or a packet is open.

Function
REQ-018 SHALL buffer input words with their TLAST bit in a DEPTH-entry FIFO; S_AXIS_TREADY = !full.
REQ-019 SHALL accept an input word only on TVALID && TREADY; when full, no push even if a pop occurs the same cycle.
REQ-020 SHALL support simultaneous push and pop when not full, occupancy unchanged.
REQ-021 SHALL implement FSM IDLE, HDR, DATA; IDLE->DATA (or HDR, see REQ-034) when FIFO non-empty, latching cfg_pkt_len and cfg_layer.
REQ-022 SHALL treat latched length 0 as 1.
REQ-023 SHALL keep latched length/layer constant for the whole packet; cfg changes affect only the next packet.
REQ-024 SHALL in DATA drive M_AXIS_TVALID = FIFO non-empty, M_AXIS_TDATA = FIFO head, combinationally from registered FIFO state (zero added latency after a word is in the FIFO).
REQ-025 SHALL count output beats; M_AXIS_TLAST = (beat == len-1) || stored TLAST of head word.
REQ-026 SHALL on a handshaked beat with TLAST return to IDLE, clear beat counter, increment pkt_count.
REQ-027 SHALL hold TDATA/TLAST stable while TVALID && !TREADY.
REQ-028 SHALL drive M_AXIS_TDATA = 0 and TLAST = 0 while TVALID low.
REQ-029 SHALL make pkt_count wrap from 2^LEN_W-1 to 0.

Reset
REQ-030 SHALL on M_AXIS_ARESETN low immediately clear FIFO pointers, FSM to IDLE, beat counter, pkt_count, latched cfg.
REQ-031 SHALL drive during reset: M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, M_AXIS_TKEEP=0, S_AXIS_TREADY=0, busy=0.
REQ-032 SHALL discard any partial packet and buffered data on reset mid-operation; first post-reset packet starts at beat 0.
REQ-033 SHALL deassert reset synchronously to M_AXIS_ACLK rising edge; S_AXIS_TREADY rises the first cycle after release.

Configuration
REQ-034 SHALL, with YOLO_PKT_HDR_EN defined, emit in HDR one header beat {8'hA5, 5'b0, layer[2:0], len[15:0]} before data, TLAST=0, not counted in len; HDR->DATA on handshake.
REQ-035 SHALL, without YOLO_PKT_HDR_EN, omit HDR state; IDLE goes directly to DATA.

Structure
REQ-036 SHALL place layer-id constants, header magic 8'hA5 and FSM state encoding in shared package yolo_pkg.
REQ-037 SHALL implement the FIFO as sub-module axis_fifo (data+last, full/empty, DEPTH parameter).

Verification
REQ-038 SHALL test len=4, 8 words streamed, TREADY=1 -> two packets, TLAST on beats 3 and 7, pkt_count=2.
REQ-039 SHALL test len=8, upstream TLAST on word 5 -> packet of 5 beats, TLAST on beat 4, next packet starts at beat 0.
REQ-040 SHALL test M_AXIS_TREADY=0 for 20 cycles with continuous input -> 16 accepted, S_AXIS_TREADY=0, no data loss/reorder after release.
REQ-041 SHALL test reset asserted after beat 2 of len=4 packet -> outputs zero same cycle, pkt_count=0, next packet TLAST at beat 3.
REQ-042 SHALL test with YOLO_PKT_HDR_EN, layer=3, len=2 -> beats 0xA5030002, d0, d1(TLAST).
REQ-043 SHALL test len=0 configured -> every data beat carries TLAST, pkt_count increments per word.
